// File: rtl/button_debouncer_pkg.sv
// Shared types and cycle-count helpers for button-style input peripherals.
// FSM state encodings plus debounce and long-press cycle derivation.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  function automatic int db_cycles(
    input int clk_hz,
    input int us
  );
    int c;
    c = (clk_hz / 1_000_000) * us;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int lp_cycles(
    input int clk_hz,
    input int ms
  );
    int c;
    c = (clk_hz / 1000) * ms;
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset level.
// Used on every asynchronous input pin.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer with press/release pulses and registered level.
// Define BTN_LONG_PRESS_EN to build the long-press hold counter.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_US   = 10_000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic btn_level_out,
  output logic toggle_flash_out,
  output logic release_out,
  output logic long_press_out
);

  localparam int DB_CYCLES = db_cycles(CLK_FREQ_HZ, DEBOUNCE_US);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic          btn_sync;
  logic          pressed;
  db_state_e     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          level_d, press_d, release_d;

  // Reset value is the raw pin level that means "released".
  sync_2ff #(
    .RST_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk(clk_in),
    .rst(rst_in),
    .d  (btn_in),
    .q  (btn_sync)
  );

  assign pressed = btn_sync ^ ACTIVE_LOW;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= RELEASED;
      cnt              <= '0;
      btn_level_out    <= 1'b0;
      toggle_flash_out <= 1'b0;
      release_out      <= 1'b0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      btn_level_out    <= level_d;
      toggle_flash_out <= press_d;
      release_out      <= release_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      RELEASED: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == DB_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    press_d   = (state == PRESS_WAIT) && (state_d == PRESSED);
    release_d = (state == RELEASE_WAIT) && (state_d == RELEASED);
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int LP_CYCLES = lp_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int HW = $clog2(LP_CYCLES + 1);
  localparam logic [HW-1:0] LP_LAST = HW'(LP_CYCLES - 1);
  localparam logic [HW-1:0] LP_SAT  = HW'(LP_CYCLES);

  logic [HW-1:0] hold, hold_d;
  logic          long_d;

  // Bouncing through RELEASE_WAIT leaves hold untouched.
  always_comb begin
    hold_d = hold;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (state == PRESSED) begin
      if (hold == LP_LAST) begin
        hold_d = LP_SAT;
        long_d = 1'b1;
      end else if (hold < LP_LAST) begin
        hold_d = hold + 1'b1;
      end
    end else if (release_d) begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hold           <= '0;
      long_press_out <= 1'b0;
    end else begin
      hold           <= hold_d;
      long_press_out <= long_d;
    end
  end
`else
  assign long_press_out = 1'b0;
`endif

endmodule
